serial_sub4: RTL and testbench

//   Bit-serial subtractor; the inverse-operation companion of the parallel 4-bit adder.

---
 rtl/serial_sub4.sv | 109 ++++++++++
 tb/tb_serial_sub4.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/serial_sub4.sv
// Bit-serial subtractor: diff = a - b - b_in, one bit per clock, LSB first.
// Operands are latched on an accepted start; the result is flagged by a one-cycle done pulse.
module serial_sub4 #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             load;
  logic             last;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [CW-1:0]    count;
  logic             brw;
  logic             d_bit;
  logic             brw_next;

  // One full-subtractor slice on the current LSBs
  assign d_bit    = a_sr[0] ^ b_sr[0] ^ brw;
  assign brw_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & brw);
  assign last     = (count == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // DONE accepts a new start just like IDLE so ops can run back-to-back
  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        if (start) begin
          load       = 1'b1;
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath; diff/b_out are captured on the edge entering DONE so they are valid with done
  always_ff @(posedge clk) begin
    if (reset) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      b_out  <= 1'b0;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      count  <= '0;
      brw    <= 1'b0;
    end else begin
      busy <= (state_next == SHIFT);
      done <= (state_next == DONE);
      if (load) begin
        a_sr   <= a;
        b_sr   <= b;
        brw    <= b_in;
        res_sr <= '0;
        count  <= '0;
      end else if (state == SHIFT) begin
        a_sr   <= a_sr >> 1;
        b_sr   <= b_sr >> 1;
        brw    <= brw_next;
        res_sr <= {d_bit, res_sr[WIDTH-1:1]};
        count  <= count + CW'(1);
        if (last) begin
          diff  <= {d_bit, res_sr[WIDTH-1:1]};
          b_out <= brw_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_sub4.sv
// Self-checking bench for serial_sub4: cycle-level reference model driven by
// directed, back-to-back, exhaustive and randomized stimulus.
module tb_serial_sub4;

  localparam int unsigned W = 4;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         b_out;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: an op is active from acceptance until its done cycle
  bit         active = 1'b0;
  int         since  = 0;
  logic [W:0] pend   = '0;
  logic [W:0] held   = '0;
  bit         m_busy = 1'b0;
  bit         m_done = 1'b0;

  serial_sub4 #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .b_in  (b_in),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .b_out (b_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the model on the edge, check outputs mid-cycle
  task automatic step(input logic s, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                      input logic tbin, input logic r);
    start = s;
    a     = ta;
    b     = tb_v;
    b_in  = tbin;
    reset = r;
    @(posedge clk);
    if (r) begin
      active = 1'b0;
      held   = '0;
    end else if (s && !m_busy) begin
      active = 1'b1;
      since  = 1;
      pend   = {1'b0, ta} - {1'b0, tb_v} - (W+1)'(tbin);
    end else if (active) begin
      since++;
    end
    if (active && since > int'(W) + 1) active = 1'b0;
    m_busy = active && (since <= int'(W));
    m_done = active && (since == int'(W) + 1);
    if (m_done) held = pend;
    @(negedge clk);
    check("busy",  busy,  m_busy);
    check("done",  done,  m_done);
    check("diff",  diff,  held[W-1:0]);
    check("b_out", b_out, held[W]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, W'($urandom), W'($urandom), 1'($urandom), 1'b0);
  endtask

  initial begin
    step(1'b0, '0, '0, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    check("rst_busy", busy, 0);
    check("rst_diff", diff, 0);

    // Directed: 9-5, 3-5, 0-0-1
    step(1'b1, 4'd9, 4'd5, 1'b0, 1'b0);
    idle(4);
    check("t1_done", done, 1);
    check("t1_diff", diff, 4'd4);
    check("t1_bout", b_out, 0);
    idle(1);
    step(1'b1, 4'd3, 4'd5, 1'b0, 1'b0);
    idle(4);
    check("t2_diff", diff, 4'hE);
    check("t2_bout", b_out, 1);
    idle(2);
    step(1'b1, 4'd0, 4'd0, 1'b1, 1'b0);
    idle(4);
    check("t2b_diff", diff, 4'hF);
    check("t2b_bout", b_out, 1);
    idle(1);

    // start held high with new operands every cycle
    for (int i = 0; i < 30; i++) step(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'b0);
    idle(6);

    // start and operand changes during SHIFT are ignored
    step(1'b1, 4'd13, 4'd6, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'b0);
    step(1'b0, 4'd0, 4'd15, 1'b1, 1'b0);
    check("t4_done", done, 1);
    check("t4_diff", diff, 4'd6);
    idle(6);

    // Reset during the second SHIFT cycle, then reset with start in the same cycle
    step(1'b1, 4'd12, 4'd3, 1'b1, 1'b0);
    idle(5);
    step(1'b1, 4'd6, 4'd1, 1'b0, 1'b0);
    idle(1);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    check("t5_busy", busy, 0);
    check("t5_diff", diff, 0);
    step(1'b1, 4'd5, 4'd2, 1'b0, 1'b1);
    step(1'b1, 4'd10, 4'd4, 1'b0, 1'b0);
    idle(4);
    check("t5_diff2", diff, 4'd6);
    idle(1);

    // Exhaustive back-to-back over all (a, b, b_in)
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      step(1'b1, v[3:0], v[7:4], v[8], 1'b0);
      idle(4);
    end
    idle(2);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 2) == 0), W'($urandom), W'($urandom), 1'($urandom),
           1'($urandom_range(0, 60) == 0));
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
